pipelined_control_decoder: RTL and testbench
============================================

Name: pipelined_control_decoder

Overview:
Registered, flow-controlled successor to the combinational RV32I control decoder. It sits between fetch and execute and decodes the full RV32I base set. Optional M-extension decode is selected by parameter. Decoded controls are held in a 2-entry skid buffer with valid/ready handshakes on both sides, a flush input, and illegal-instruction detection.

Parameters:
XLEN, 32, width of the PC carried alongside the instruction
M_EXT, 0, 1 = decode MUL/DIV/REM family; 0 = those encodings flag illegal
ALU_SEL_W, 5, width of alu_select; must be >= 5

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  discard all buffered entries and any input on this cycle
in_valid  in  1  instruction/in_pc valid
in_ready  out  1  decoder can accept this cycle
instruction  in  32  raw instruction
in_pc  in  XLEN  PC of instruction
out_valid  out  1  decoded entry valid
out_ready  in  1  execute accepts entry
out_pc  out  XLEN  PC of the output entry
out_instruction  out  32  raw instruction of the output entry
pc_select  out  1  1 = jal/jalr redirect
branch  out  1  conditional branch; branch_type = funct3
branch_type  out  3  funct3 of the branch
immediate_select  out  3  000 none, 001 I, 010 S, 011 B, 100 U, 101 J
a_select  out  1  0 = rs1, 1 = PC
b_select  out  1  0 = rs2, 1 = immediate
alu_select  out  ALU_SEL_W  0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and, 15 pass-B, 16–23 mul, mulh, mulhsu, mulhu, div, divu, rem, remu
mem_read  out  1  load
mem_write  out  1  store
mem_size  out  3  funct3 of the load/store
register_write_enable  out  1  write rd
write_back_select  out  2  00 memory, 01 ALU, 10 PC+4
illegal  out  1  unrecognised or disallowed encoding

Behaviour:
- Reset: out_valid=0 and every decoded output is 0. in_ready=0 while rst is high and 1 on the first cycle after.
- Transfers: input accepted when in_valid & in_ready; output consumed when out_valid & out_ready.
- Latency: an instruction accepted in cycle N is presented with out_valid=1 in cycle N+1. One entry per cycle under no backpressure.
- Buffer: main entry (drives outputs) plus one skid entry.
  - in_ready is registered and equals !skid_valid.
  - Accept while main is full and not consumed: the instruction goes to skid.
  - Main consumed while skid is full: skid moves to main. The new input, if any, goes to skid.
  - Order is always preserved. Nothing is lost or duplicated.
- Outputs are stable while out_valid=1 and out_ready=0.
- Flush (wins over every other event):
  - Next cycle: out_valid=0, skid empty, in_ready=1.
  - The input on the flush cycle is dropped even if in_valid & in_ready.
- Decode rules (the opcode not listed below is illegal):
  - OP-IMM (0010011): imm 001, b 1, wb 01, rwe 1. alu from funct3; srai = 7 when funct7=0100000.
  - OP (0110011), funct7=0000000: alu from funct3.
  - OP (0110011), funct7=0100000: funct3 000 gives sub, 101 gives sra; other funct3 illegal.
  - OP (0110011), funct7=0000001: M_EXT=1 gives alu 16+funct3; M_EXT=0 illegal.
  - OP, other funct7: illegal. Valid OP instructions drive b 0, wb 01, rwe 1.
  - LUI: imm 100, b 1, alu 15, wb 01, rwe 1.
  - AUIPC: imm 100, a 1, b 1, alu 0, wb 01, rwe 1.
  - JAL: pc_sel 1, imm 101, a 1, b 1, alu 0, wb 10, rwe 1.
  - JALR (funct3 000 only): pc_sel 1, imm 001, b 1, alu 0, wb 10, rwe 1.
  - BRANCH: branch 1, branch_type funct3 (010 and 011 illegal), imm 011, a 1, b 1, alu 0, rwe 0.
  - LOAD: mem_read 1, mem_size funct3 (011, 110 and 111 illegal), imm 001, b 1, alu 0, wb 00, rwe 1.
  - STORE: mem_write 1, mem_size funct3 (>010 illegal), imm 010, b 1, alu 0, rwe 0.
- rd==0: register_write_enable forced to 0. illegal is unaffected.
- Illegal entries: still passed through with out_valid=1 and illegal=1. All other controls are 0; rwe, mem_read, mem_write and pc_select are guaranteed 0.
- Reset mid-stream: both entries are discarded, as for flush, and outputs return to 0.

Test Plan:
- Single instruction 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle: out_valid=1, imm 001, b 1, alu 0, rwe 1, wb 01, illegal 0.
- 0x002081B3 (add) then 0x402081B3 (sub) back-to-back -> alu 0 then alu 1 on consecutive cycles. 0x00000013 (nop) -> rwe 0.
- 0x022081B3 (mul) -> alu 16 with M_EXT=1. With M_EXT=0: illegal 1, rwe 0.
- 0x00812283 (lw) -> mem_read 1, mem_size 010, wb 00, rwe 1. 0x00512423 (sw) -> mem_write 1, imm 010, rwe 0.
- Stream A, B, C, D with out_ready low for 3 cycles -> in_ready falls after A and B are accepted. Release out_ready -> A, B, C, D emerge in order with no gaps or duplicates.
- Buffer full, assert flush with in_valid=1 -> next cycle out_valid 0, in_ready 1. The flushed and incoming instructions never appear on the output.

Source files
------------

// File: rtl/pipelined_control_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_control_decoder
// Brief    : Registered RV32I(+M) control decoder between fetch and execute.
//            Decoded controls sit in a two-entry skid buffer (main + skid)
//            with valid/ready on both sides, flush, and illegal detection.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_control_decoder #(
    parameter int XLEN      = 32,
    parameter int M_EXT     = 0,
    parameter int ALU_SEL_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instruction,
    input  logic [XLEN-1:0]      in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [31:0]          out_instruction,
    output logic                 pc_select,
    output logic                 branch,
    output logic [2:0]           branch_type,
    output logic [2:0]           immediate_select,
    output logic                 a_select,
    output logic                 b_select,
    output logic [ALU_SEL_W-1:0] alu_select,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [2:0]           mem_size,
    output logic                 register_write_enable,
    output logic [1:0]           write_back_select,
    output logic                 illegal
);

    localparam logic [6:0] c_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OP     = 7'b0110011;
    localparam logic [6:0] c_LUI    = 7'b0110111;
    localparam logic [6:0] c_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_JAL    = 7'b1101111;
    localparam logic [6:0] c_JALR   = 7'b1100111;
    localparam logic [6:0] c_BRANCH = 7'b1100011;
    localparam logic [6:0] c_LOAD   = 7'b0000011;
    localparam logic [6:0] c_STORE  = 7'b0100011;
    localparam logic       c_M_EXT  = (M_EXT != 0);

    typedef struct packed {
        logic                 pc_select;
        logic                 branch;
        logic [2:0]           branch_type;
        logic [2:0]           immediate_select;
        logic                 a_select;
        logic                 b_select;
        logic [ALU_SEL_W-1:0] alu_select;
        logic                 mem_read;
        logic                 mem_write;
        logic [2:0]           mem_size;
        logic                 register_write_enable;
        logic [1:0]           write_back_select;
        logic                 illegal;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        ctrl_t           ctrl;
    } entry_t;

    // Base ALU operation for a funct3; alt selects arithmetic shift right.
    function automatic logic [ALU_SEL_W-1:0] alu_of_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_of_funct3 = ALU_SEL_W'(0);
            3'b001:  alu_of_funct3 = ALU_SEL_W'(2);
            3'b010:  alu_of_funct3 = ALU_SEL_W'(3);
            3'b011:  alu_of_funct3 = ALU_SEL_W'(4);
            3'b100:  alu_of_funct3 = ALU_SEL_W'(5);
            3'b101:  alu_of_funct3 = alt ? ALU_SEL_W'(7) : ALU_SEL_W'(6);
            3'b110:  alu_of_funct3 = ALU_SEL_W'(8);
            default: alu_of_funct3 = ALU_SEL_W'(9);
        endcase
    endfunction

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic [4:0] w_rd;
    logic       w_bad;
    ctrl_t      w_raw;
    ctrl_t      w_dec;

    assign w_opcode = instruction[6:0];
    assign w_funct3 = instruction[14:12];
    assign w_funct7 = instruction[31:25];
    assign w_rd     = instruction[11:7];

    // Decode the incoming instruction into raw controls plus an illegal flag.
    always_comb begin
        w_raw = '0;
        w_bad = 1'b0;
        case (w_opcode)
            c_OP_IMM: begin
                w_raw.immediate_select      = 3'b001;
                w_raw.b_select              = 1'b1;
                w_raw.alu_select            = alu_of_funct3(w_funct3, w_funct7 == 7'b0100000);
                w_raw.write_back_select     = 2'b01;
                w_raw.register_write_enable = 1'b1;
            end
            c_OP: begin
                w_raw.write_back_select     = 2'b01;
                w_raw.register_write_enable = 1'b1;
                case (w_funct7)
                    7'b0000000: w_raw.alu_select = alu_of_funct3(w_funct3, 1'b0);
                    7'b0100000: begin
                        if (w_funct3 == 3'b000)      w_raw.alu_select = ALU_SEL_W'(1);
                        else if (w_funct3 == 3'b101) w_raw.alu_select = ALU_SEL_W'(7);
                        else                         w_bad = 1'b1;
                    end
                    7'b0000001: begin
                        if (c_M_EXT) w_raw.alu_select = ALU_SEL_W'(16) + ALU_SEL_W'(w_funct3);
                        else         w_bad = 1'b1;
                    end
                    default: w_bad = 1'b1;
                endcase
            end
            c_LUI: begin
                w_raw.immediate_select      = 3'b100;
                w_raw.b_select              = 1'b1;
                w_raw.alu_select            = ALU_SEL_W'(15);
                w_raw.write_back_select     = 2'b01;
                w_raw.register_write_enable = 1'b1;
            end
            c_AUIPC: begin
                w_raw.immediate_select      = 3'b100;
                w_raw.a_select              = 1'b1;
                w_raw.b_select              = 1'b1;
                w_raw.write_back_select     = 2'b01;
                w_raw.register_write_enable = 1'b1;
            end
            c_JAL: begin
                w_raw.pc_select             = 1'b1;
                w_raw.immediate_select      = 3'b101;
                w_raw.a_select              = 1'b1;
                w_raw.b_select              = 1'b1;
                w_raw.write_back_select     = 2'b10;
                w_raw.register_write_enable = 1'b1;
            end
            c_JALR: begin
                w_bad                       = (w_funct3 != 3'b000);
                w_raw.pc_select             = 1'b1;
                w_raw.immediate_select      = 3'b001;
                w_raw.b_select              = 1'b1;
                w_raw.write_back_select     = 2'b10;
                w_raw.register_write_enable = 1'b1;
            end
            c_BRANCH: begin
                w_bad                  = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
                w_raw.branch           = 1'b1;
                w_raw.branch_type      = w_funct3;
                w_raw.immediate_select = 3'b011;
                w_raw.a_select         = 1'b1;
                w_raw.b_select         = 1'b1;
            end
            c_LOAD: begin
                w_bad = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
                w_raw.mem_read              = 1'b1;
                w_raw.mem_size              = w_funct3;
                w_raw.immediate_select      = 3'b001;
                w_raw.b_select              = 1'b1;
                w_raw.write_back_select     = 2'b00;
                w_raw.register_write_enable = 1'b1;
            end
            c_STORE: begin
                w_bad                  = (w_funct3 > 3'b010);
                w_raw.mem_write        = 1'b1;
                w_raw.mem_size         = w_funct3;
                w_raw.immediate_select = 3'b010;
                w_raw.b_select         = 1'b1;
            end
            default: w_bad = 1'b1;
        endcase
    end

    // Illegal entries carry only the illegal flag; rd==x0 never writes back.
    always_comb begin
        w_dec = w_raw;
        if (w_bad) begin
            w_dec         = '0;
            w_dec.illegal = 1'b1;
        end else if (w_rd == 5'd0) begin
            w_dec.register_write_enable = 1'b0;
        end
    end

    entry_t r_main;
    entry_t r_skid;
    logic   r_main_valid;
    logic   r_skid_valid;
    logic   r_in_ready;

    entry_t w_new;
    entry_t w_main_nxt;
    entry_t w_skid_nxt;
    logic   w_main_valid_nxt;
    logic   w_skid_valid_nxt;
    logic   w_accept;
    logic   w_consume;

    assign w_new     = '{pc: in_pc, instr: instruction, ctrl: w_dec};
    assign w_accept  = in_valid && in_ready && !flush;
    assign w_consume = r_main_valid && out_ready;

    // Skid-buffer next state: main refills from skid first to keep order.
    always_comb begin
        w_main_nxt       = r_main;
        w_skid_nxt       = r_skid;
        w_main_valid_nxt = r_main_valid;
        w_skid_valid_nxt = r_skid_valid;
        if (!r_main_valid || w_consume) begin
            if (r_skid_valid) begin
                w_main_nxt       = r_skid;
                w_main_valid_nxt = 1'b1;
                w_skid_valid_nxt = w_accept;
                if (w_accept) w_skid_nxt = w_new;
            end else begin
                w_main_valid_nxt = w_accept;
                if (w_accept) w_main_nxt = w_new;
            end
        end else if (w_accept) begin
            w_skid_nxt       = w_new;
            w_skid_valid_nxt = 1'b1;
        end
    end

    // Buffer registers; reset and flush both drop every buffered entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_main       <= w_main_nxt;
            r_skid       <= w_skid_nxt;
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= !w_skid_valid_nxt;
        end
    end

    // Ready is held low for the whole reset window.
    assign in_ready = r_in_ready && !rst;

    entry_t w_out;
    assign w_out = r_main_valid ? r_main : '0;

    assign out_valid             = r_main_valid;
    assign out_pc                = w_out.pc;
    assign out_instruction       = w_out.instr;
    assign pc_select             = w_out.ctrl.pc_select;
    assign branch                = w_out.ctrl.branch;
    assign branch_type           = w_out.ctrl.branch_type;
    assign immediate_select      = w_out.ctrl.immediate_select;
    assign a_select              = w_out.ctrl.a_select;
    assign b_select              = w_out.ctrl.b_select;
    assign alu_select            = w_out.ctrl.alu_select;
    assign mem_read              = w_out.ctrl.mem_read;
    assign mem_write             = w_out.ctrl.mem_write;
    assign mem_size              = w_out.ctrl.mem_size;
    assign register_write_enable = w_out.ctrl.register_write_enable;
    assign write_back_select     = w_out.ctrl.write_back_select;
    assign illegal               = w_out.ctrl.illegal;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_control_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_control_decoder
// Brief    : Scoreboard bench for pipelined_control_decoder; one instance
//            with M extension enabled and one with it disabled, same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_control_decoder;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] instruction, in_pc;

    // M_EXT=1 instance outputs
    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_instruction;
    logic        pc_select, branch, a_select, b_select, mem_read, mem_write, rwe, illegal;
    logic [2:0]  branch_type, immediate_select, mem_size;
    logic [4:0]  alu_select;
    logic [1:0]  wb_sel;

    // M_EXT=0 instance outputs
    logic        m0_in_ready, m0_out_valid;
    logic [31:0] m0_out_pc, m0_out_instruction;
    logic        m0_pc_select, m0_branch, m0_a_select, m0_b_select, m0_mem_read, m0_mem_write, m0_rwe, m0_illegal;
    logic [2:0]  m0_branch_type, m0_immediate_select, m0_mem_size;
    logic [4:0]  m0_alu_select;
    logic [1:0]  m0_wb_sel;

    pipelined_control_decoder #(.XLEN(32), .M_EXT(1), .ALU_SEL_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instruction(out_instruction), .pc_select(pc_select),
        .branch(branch), .branch_type(branch_type), .immediate_select(immediate_select),
        .a_select(a_select), .b_select(b_select), .alu_select(alu_select),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .register_write_enable(rwe), .write_back_select(wb_sel), .illegal(illegal)
    );

    pipelined_control_decoder #(.XLEN(32), .M_EXT(0), .ALU_SEL_W(5)) dut_m0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(m0_in_ready),
        .instruction(instruction), .in_pc(in_pc), .out_valid(m0_out_valid), .out_ready(out_ready),
        .out_pc(m0_out_pc), .out_instruction(m0_out_instruction), .pc_select(m0_pc_select),
        .branch(m0_branch), .branch_type(m0_branch_type), .immediate_select(m0_immediate_select),
        .a_select(m0_a_select), .b_select(m0_b_select), .alu_select(m0_alu_select),
        .mem_read(m0_mem_read), .mem_write(m0_mem_write), .mem_size(m0_mem_size),
        .register_write_enable(m0_rwe), .write_back_select(m0_wb_sel), .illegal(m0_illegal)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference decode: {pc_sel,branch,btype,imm,a,b,alu,mr,mw,msize,rwe,wb,illegal}
    function automatic logic [23:0] ref_ctrl(input logic [31:0] ins, input bit mext);
        logic [4:0] tbl [0:7];
        logic [6:0] op;
        logic [2:0] f3, bt, im, ms;
        logic [6:0] f7;
        logic       pcs, br, a, b, mr, mw, we, ill;
        logic [4:0] alu;
        logic [1:0] wb;
        tbl = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        {pcs, br, bt, im, a, b, alu, mr, mw, ms, we, wb, ill} = '0;
        case (op)
            7'h13: begin
                im = 3'd1; b = 1; wb = 2'd1; we = 1; alu = tbl[f3];
                if (f3 == 3'd5 && f7 == 7'h20) alu = 5'd7;
            end
            7'h33: begin
                wb = 2'd1; we = 1;
                if (f7 == 7'h00) alu = tbl[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) alu = 5'd1;
                else if (f7 == 7'h20 && f3 == 3'd5) alu = 5'd7;
                else if (f7 == 7'h01 && mext) alu = 5'd16 + {2'b00, f3};
                else ill = 1;
            end
            7'h37: begin im = 3'd4; b = 1; alu = 5'd15; wb = 2'd1; we = 1; end
            7'h17: begin im = 3'd4; a = 1; b = 1; wb = 2'd1; we = 1; end
            7'h6f: begin pcs = 1; im = 3'd5; a = 1; b = 1; wb = 2'd2; we = 1; end
            7'h67: begin ill = (f3 != 0); pcs = 1; im = 3'd1; b = 1; wb = 2'd2; we = 1; end
            7'h63: begin ill = (f3 == 2 || f3 == 3); br = 1; bt = f3; im = 3'd3; a = 1; b = 1; end
            7'h03: begin ill = (f3 == 3 || f3 == 6 || f3 == 7); mr = 1; ms = f3; im = 3'd1; b = 1; we = 1; end
            7'h23: begin ill = (f3 > 2); mw = 1; ms = f3; im = 3'd2; b = 1; end
            default: ill = 1;
        endcase
        if (ill) return 24'h000001;
        if (ins[11:7] == 5'd0) we = 0;
        return {pcs, br, bt, im, a, b, alu, mr, mw, ms, we, wb, 1'b0};
    endfunction

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [23:0] c1;
        logic [23:0] c0;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] pc_ctr = 32'h1000;
    bit          rand_rdy = 0;

    wire [23:0] obs_c1 = {pc_select, branch, branch_type, immediate_select, a_select, b_select,
                          alu_select, mem_read, mem_write, mem_size, rwe, wb_sel, illegal};
    wire [23:0] obs_c0 = {m0_pc_select, m0_branch, m0_branch_type, m0_immediate_select, m0_a_select,
                          m0_b_select, m0_alu_select, m0_mem_read, m0_mem_write, m0_mem_size,
                          m0_rwe, m0_wb_sel, m0_illegal};

    // Scoreboard: compare on consume, then record accepted input (flush drops all).
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", out_valid, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_pc", out_pc, e.pc);
                    check("out_instr", out_instruction, e.ins);
                    check("ctrl_m1", obs_c1, e.c1);
                    check("m0_valid", m0_out_valid, 1);
                    check("ctrl_m0", obs_c0, e.c0);
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready)
                sb.push_back('{pc: in_pc, ins: instruction, c1: ref_ctrl(instruction, 1), c0: ref_ctrl(instruction, 0)});
        end
    end

    // Random backpressure during the random phase.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Present an instruction and hold it until accepted; returns 1ns after the accepting edge.
    task automatic push(input logic [31:0] ins);
        bit ok;
        int cyc;
        in_valid = 1; instruction = ins; in_pc = pc_ctr;
        ok = 0; cyc = 0;
        while (!ok && cyc < 100) begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1;
            cyc++;
        end
        if (!ok) check("push_timeout", in_ready, 1);
        in_valid = 0;
        pc_ctr += 4;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [0:9];
        logic [31:0] r;
        ops = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h0b};
        r = $urandom;
        r[6:0] = ops[$urandom_range(0, 9)];
        if (r[6:0] == 7'h33) begin
            case ($urandom_range(0, 3))
                0: r[31:25] = 7'h00;
                1: r[31:25] = 7'h20;
                2: r[31:25] = 7'h01;
                default: ;
            endcase
        end
        return r;
    endfunction

    initial begin
        rst = 1; flush = 0; in_valid = 0; out_ready = 1; instruction = 0; in_pc = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_ctrl", obs_c1, 0);
        @(posedge clk); #1 rst = 0;
        #2 check("post_rst_in_ready", in_ready, 1);

        // addi x1,x0,5
        push(32'h00500093);
        #2;
        check("addi_valid", out_valid, 1);
        check("addi_imm", immediate_select, 3'b001);
        check("addi_b", b_select, 1);
        check("addi_alu", alu_select, 0);
        check("addi_rwe", rwe, 1);
        check("addi_wb", wb_sel, 2'b01);
        check("addi_illegal", illegal, 0);

        // add then sub back-to-back
        push(32'h002081B3);
        #2 check("add_alu", alu_select, 0);
        push(32'h402081B3);
        #2 check("sub_alu", alu_select, 1);
        push(32'h00000013);
        #2 check("nop_rwe", rwe, 0);

        // mul: decoded with M, illegal without
        push(32'h022081B3);
        #2;
        check("mul_alu", alu_select, 16);
        check("mul_m0_illegal", m0_illegal, 1);
        check("mul_m0_rwe", m0_rwe, 0);

        push(32'h00812283);
        #2;
        check("lw_mr", mem_read, 1);
        check("lw_size", mem_size, 3'b010);
        check("lw_wb", wb_sel, 2'b00);
        check("lw_rwe", rwe, 1);
        push(32'h00512423);
        #2;
        check("sw_mw", mem_write, 1);
        check("sw_imm", immediate_select, 3'b010);
        check("sw_rwe", rwe, 0);
        @(posedge clk); #1;

        // Stream A..D under 3 cycles of backpressure
        out_ready = 0;
        fork
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1;
                repeat (4) begin
                    @(negedge clk);
                    check("stream_nogap", out_valid, 1);
                end
            end
        join_none
        push(32'h00100113);
        push(32'h00200193);
        @(negedge clk);
        check("stream_in_ready_low", in_ready, 0);
        check("stream_hold_a", out_instruction, 32'h00100113);
        push(32'h00300213);
        push(32'h00400293);
        repeat (3) @(posedge clk);
        #1;

        // Flush with both entries full and a valid input present
        out_ready = 0;
        push(32'h00500313);
        push(32'h00600393);
        in_valid = 1; instruction = 32'h00700413; in_pc = pc_ctr; flush = 1;
        @(posedge clk); #1 flush = 0; in_valid = 0; pc_ctr += 4;
        #2;
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        out_ready = 1;
        push(32'h00800493);
        #2 check("post_flush_instr", out_instruction, 32'h00800493);
        @(posedge clk); #1;

        // Reset mid-stream
        out_ready = 0;
        push(32'h00900513);
        push(32'h00a00593);
        rst = 1;
        @(posedge clk); #1 rst = 0;
        #2;
        check("midrst_valid", out_valid, 0);
        check("midrst_instr", out_instruction, 0);
        check("midrst_in_ready", in_ready, 1);
        out_ready = 1;

        // Random instructions under random backpressure
        rand_rdy = 1;
        for (int i = 0; i < 60; i++) push(rand_instr());
        rand_rdy = 0;
        @(posedge clk); #1 out_ready = 1;
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
